md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//   Parametrised multi-cycle multiply/divide unit with HI/LO registers for the MIPS datapath.
//   Sits beside the ALU in the execute stage. Adds MULT/MULTU/DIV/DIVU, MFHI/MFLO and MTHI/MTLO.
//   Multi-cycle operations raise Busy. The controller stalls any MD instruction while Busy|Start.
// PARAMETERS
//   WIDTH        32  operand and HI/LO width
//   MULT_CYCLES  5   cycles Busy stays high for MULT/MULTU (>=1)
//   DIV_CYCLES   10  cycles Busy stays high for DIV/DIVU (>=1)
// PORTS
//   clk     in   1      system clock, all state on rising edge
//   reset   in   1      synchronous, active-high; clears all state
//   Start   in   1      operation request, valid for the cycle it is high
//   MDOp    in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
//   A       in   WIDTH  operand rs (multiplicand/dividend; MTHI/MTLO source)
//   B       in   WIDTH  operand rt (multiplier/divisor)
//   Busy    out  1      multi-cycle operation in flight
//   HI      out  WIDTH  HI register
//   LO      out  WIDTH  LO register
//   MDOut   out  WIDTH  combinational: HI when MDOp==6, LO when MDOp==7, else 0
// BEHAVIOUR
//   Reset: HI=0, LO=0, Busy=0, cycle counter=0, operand latches=0. Reset wins over Start, also mid-operation.
//   States: IDLE, RUN.
//   IDLE & Start & MDOp in {0..3}:
//     - latch A, B, MDOp
//     - load counter with MULT_CYCLES or DIV_CYCLES
//     - go to RUN; Busy=1 from the next cycle
//   RUN: counter decrements each cycle. When the counter reaches 1:
//     - HI/LO take the result on that edge
//     - Busy drops; next state is IDLE
//     - net: Busy is high for exactly N cycles; HI/LO are valid the cycle Busy falls
//   Results:
//     - MULT: {HI,LO} = signed A * signed B (2*WIDTH-bit product)
//     - MULTU: unsigned product
//     - DIV: LO = quotient truncated toward zero; HI = remainder, sign of the dividend
//     - DIVU: unsigned quotient and remainder
//     - Divisor 0 (DIV/DIVU): operation still takes DIV_CYCLES; HI and LO are left unchanged
//     - DIV with A = most-negative, B = -1: LO = A, HI = 0 (wrap, no trap)
//   IDLE & Start & MDOp==4: HI <= A on the same edge; MDOp==5: LO <= A. No Busy.
//   MDOp 6/7: read only; Start has no state effect.
//   Start while Busy: ignored entirely, including MTHI/MTLO; operands are not re-latched.
//   Operands: A/B may change after the Start cycle without affecting the result.
//   MDOut reflects HI/LO registers (old value during RUN; no forwarding of pending results).
// TESTING
//   1. Reset, then MULT A=32'hFFFF_FFFE(-2), B=3:
//      Busy high 5 cycles; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
//   2. MULTU A=32'hFFFF_FFFF, B=32'hFFFF_FFFF:
//      after 5 cycles HI=32'hFFFF_FFFE, LO=32'h0000_0001.
//   3. DIV A=-7, B=2 -> after 10 cycles LO=-3, HI=-1.
//      DIVU A=7, B=2 -> LO=3, HI=1.
//      DIV A=32'h8000_0000, B=-1 -> LO=32'h8000_0000, HI=0.
//   4. MTHI A=5, then DIV A=9, B=0:
//      Busy 10 cycles; HI stays 5, LO stays 0; MFHI gives MDOut=5.
//   5. MULT A=2, B=3, with Start+MTLO A=99 and Start+DIV on cycles 2-3 of the run:
//      both ignored; final HI=0, LO=6.
//   6. Start DIV, assert reset on cycle 4 -> next cycle Busy=0, HI=LO=0.
//      Then a new MULT 4*4 completes normally: LO=16.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Operands are latched at Start, so A/B may change during the run.
// The result is written to HI/LO on the edge where the down-counter reaches 1.
//
// state  | meaning
// IDLE   | waiting for Start; MTHI/MTLO complete in one edge
// RUN    | multiply/divide in flight, Busy high, counter decrementing
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] MDOut
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [1:0]       op_q,    op_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;

  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic        [WIDTH-1:0]   b_safe;
  logic signed [WIDTH-1:0]   quot_s, rem_s;
  logic        [WIDTH-1:0]   quot_u, rem_u;
  logic                      div_zero;
  logic                      div_ovf;

  // Datapath: products and quotients from the latched operands.
  // A zero divisor is swapped for 1 so the dividers never see it; that result is discarded.
  always_comb begin
    prod_s   = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    prod_u   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    div_zero = (b_q == '0);
    b_safe   = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;
    div_ovf  = (a_q == MOST_NEG) && (b_q == ALL_ONES);
    quot_s   = $signed(a_q) / $signed(b_safe);
    rem_s    = $signed(a_q) % $signed(b_safe);
    quot_u   = a_q / b_safe;
    rem_u    = a_q % b_safe;
    if (div_ovf) begin
      quot_s = $signed(MOST_NEG);
      rem_s  = '0;
    end
  end

  // Next-state logic for the controller, operand latches and HI/LO.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (MDOp)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              a_d     = A;
              b_d     = B;
              op_d    = MDOp[1:0];
              cnt_d   = MDOp[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              state_d = S_RUN;
            end
            3'd4:    hi_d = A;
            3'd5:    lo_d = A;
            default: ;
          endcase
        end
      end
      default: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          case (op_q)
            OP_MULT: begin
              hi_d = prod_s[2*WIDTH-1:WIDTH];
              lo_d = prod_s[WIDTH-1:0];
            end
            OP_MULTU: begin
              hi_d = prod_u[2*WIDTH-1:WIDTH];
              lo_d = prod_u[WIDTH-1:0];
            end
            OP_DIV: begin
              if (!div_zero) begin
                hi_d = rem_s;
                lo_d = quot_s;
              end
            end
            default: begin
              if (!div_zero) begin
                hi_d = rem_u;
                lo_d = quot_u;
              end
            end
          endcase
        end
      end
    endcase
  end

  // State registers; reset takes priority over everything, including a run in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Read port: registered HI/LO only, no forwarding of a pending result.
  always_comb begin
    case (MDOp)
      3'd6:    MDOut = hi_q;
      3'd7:    MDOut = lo_q;
      default: MDOut = '0;
    endcase
  end

  assign Busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit; expected values are hand-computed constants.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDOut;

  int n_cmp;
  int n_fail;
  int busy_cnt;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO),
    .MDOut (MDOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one Start cycle at a negedge; operands are scrambled afterwards.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    MDOp  = 3'd0;
    A     = 32'hDEAD_BEEF;
    B     = 32'h1234_5678;
  endtask

  // Counts negedges with Busy high, starting at the current negedge; bounded.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (Busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    Start  = 1'b0;
    MDOp   = 3'd0;
    A      = '0;
    B      = '0;
    repeat (2) @(posedge clk);
    do_reset();

    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    MDOp = 3'd6;
    #1 check("reset_mfhi", MDOut, 32'd0);
    MDOp = 3'd0;

    // 1: signed multiply -2 * 3
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    check("mult_lo_during_run", LO, 32'd0);
    wait_idle(busy_cnt);
    check("mult_busy_cycles", busy_cnt, 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    // 2: unsigned multiply of all-ones
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    MDOp = 3'd7;
    #1 check("multu_mflo_old", MDOut, 32'hFFFF_FFFA);
    wait_idle(busy_cnt);
    check("multu_busy_cycles", busy_cnt, 32'd5);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);

    // 3: divides
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(busy_cnt);
    check("div_busy_cycles", busy_cnt, 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    issue(3'd3, 32'd7, 32'd2);
    wait_idle(busy_cnt);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(busy_cnt);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'd0);

    // 4: MTHI then divide by zero
    do_reset();
    issue(3'd4, 32'd5, 32'd0);
    check("mthi_no_busy", {31'd0, Busy}, 32'd0);
    check("mthi_hi", HI, 32'd5);
    issue(3'd2, 32'd9, 32'd0);
    wait_idle(busy_cnt);
    check("div0_busy_cycles", busy_cnt, 32'd10);
    check("div0_hi", HI, 32'd5);
    check("div0_lo", LO, 32'd0);
    MDOp = 3'd6;
    #1 check("mfhi_out", MDOut, 32'd5);
    MDOp = 3'd7;
    #1 check("mflo_out", MDOut, 32'd0);
    MDOp = 3'd0;
    #1 check("mdout_other_op", MDOut, 32'd0);

    // 5: Starts during a run are ignored
    issue(3'd0, 32'd2, 32'd3);
    Start = 1'b1;
    MDOp  = 3'd5;
    A     = 32'd99;
    @(posedge clk);
    @(negedge clk);
    MDOp  = 3'd2;
    A     = 32'd100;
    B     = 32'd7;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    MDOp  = 3'd0;
    check("ignored_mtlo_lo", LO, 32'd0);
    wait_idle(busy_cnt);
    check("ignored_busy_cycles", busy_cnt + 2, 32'd5);
    check("ignored_hi", HI, 32'd0);
    check("ignored_lo", LO, 32'd6);
    @(negedge clk);
    check("ignored_no_restart", {31'd0, Busy}, 32'd0);

    // 6: reset mid-divide, then a fresh multiply
    issue(3'd2, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    check("pre_reset_busy", {31'd0, Busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrun_reset_busy", {31'd0, Busy}, 32'd0);
    check("midrun_reset_hi", HI, 32'd0);
    check("midrun_reset_lo", LO, 32'd0);
    issue(3'd0, 32'd4, 32'd4);
    wait_idle(busy_cnt);
    check("post_reset_busy_cycles", busy_cnt, 32'd5);
    check("post_reset_lo", LO, 32'd16);
    check("post_reset_hi", HI, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
